mario_sprite_fetch: RTL

MARIO_SPRITE_FETCH -- requirements
Module: mario_sprite_fetch

---
 rtl/sprite_pkg.sv | 26 ++
 rtl/sprite_pos_latch.sv | 48 ++++
 rtl/mario_sprite_fetch.sv | 92 +++++++++
 3 files changed

// File: rtl/sprite_pkg.sv
// rtl/sprite_pkg.sv - shared constants, FSM state type and shift-add multiply helper
package sprite_pkg;

    localparam int          SPRITE_W_DEF    = 21;
    localparam int          SPRITE_H_DEF    = 41;
    localparam logic [23:0] TRANSPARENT_DEF = 24'h800080;
    localparam int          ROM_AW          = 10;

    typedef enum logic {
        LATCH_IDLE    = 1'b0,
        LATCH_PENDING = 1'b1
    } latch_state_t;

    // Constant multiply as a shift-add chain; k is elaborated, so only the set bits cost adders
    function automatic logic [ROM_AW-1:0] mul_const(input logic [ROM_AW-1:0] a, input int unsigned k);
        logic [ROM_AW-1:0] acc;
        acc = '0;
        for (int i = 0; i < ROM_AW; i++) begin
            if (k[i]) begin
                acc = acc + (a << i);
            end
        end
        return acc;
    endfunction

endpackage

// File: rtl/sprite_pos_latch.sv
// rtl/sprite_pos_latch.sv - frame-synchronous shadow registers for sprite position and facing
module sprite_pos_latch
    import sprite_pkg::*;
(
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_start,
    input  logic [9:0] sprite_x,
    input  logic [9:0] sprite_y,
    input  logic       facing_left,
    output logic [9:0] sx,
    output logic [9:0] sy,
    output logic       facing
);

    latch_state_t state;
    latch_state_t state_next;
    logic         changed;

    assign changed = (sprite_x != sx) || (sprite_y != sy) || (facing_left != facing);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state  <= LATCH_IDLE;
            sx     <= '0;
            sy     <= '0;
            facing <= 1'b0;
        end else begin
            state <= state_next;
            if (frame_start) begin
                sx     <= sprite_x;
                sy     <= sprite_y;
                facing <= facing_left;
            end
        end
    end

    // PENDING marks the single cycle after a frame_start that actually moved the sprite
    always_comb begin
        state_next = LATCH_IDLE;
        case (state)
            LATCH_IDLE:    state_next = (frame_start && changed) ? LATCH_PENDING : LATCH_IDLE;
            LATCH_PENDING: state_next = (frame_start && changed) ? LATCH_PENDING : LATCH_IDLE;
            default:       state_next = LATCH_IDLE;
        endcase
    end

endmodule

// File: rtl/mario_sprite_fetch.sv
// rtl/mario_sprite_fetch.sv - two-stage sprite hit test and ROM fetch; SPRITE_MIRROR_EN enables horizontal mirroring
module mario_sprite_fetch
    import sprite_pkg::*;
#(
    parameter int          SPRITE_W    = SPRITE_W_DEF,
    parameter int          SPRITE_H    = SPRITE_H_DEF,
    parameter logic [23:0] TRANSPARENT = TRANSPARENT_DEF
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              frame_start,
    input  logic              pixel_valid,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic [9:0]        sprite_x,
    input  logic [9:0]        sprite_y,
    input  logic              facing_left,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [23:0]       rom_color,
    output logic              out_valid,
    output logic              sprite_hit,
    output logic [23:0]       sprite_color
);

    logic [9:0]        sx;
    logic [9:0]        sy;
    logic              facing;
    logic [10:0]       dx;
    logic [10:0]       dy;
    logic              in_box;
    logic [9:0]        col;
    logic [ROM_AW-1:0] addr_next;
    logic              v1;
    logic              in1;
    logic              hit_next;

    sprite_pos_latch u_latch (
        .Clk         (Clk),
        .Reset       (Reset),
        .frame_start (frame_start),
        .sprite_x    (sprite_x),
        .sprite_y    (sprite_y),
        .facing_left (facing_left),
        .sx          (sx),
        .sy          (sy),
        .facing      (facing)
    );

    // 11-bit differences so a sprite hanging past column 1023 goes negative instead of wrapping
    assign dx = {1'b0, DrawX} - {1'b0, sx};
    assign dy = {1'b0, DrawY} - {1'b0, sy};

    assign in_box = !dx[10] && (dx < 11'(SPRITE_W)) &&
                    !dy[10] && (dy < 11'(SPRITE_H));

`ifdef SPRITE_MIRROR_EN
    assign col = facing ? (10'(SPRITE_W - 1) - dx[9:0]) : dx[9:0];
`else
    logic unused_facing;
    assign unused_facing = facing;
    assign col = dx[9:0];
`endif

    assign addr_next = mul_const(dy[9:0], SPRITE_W) + col;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            v1       <= 1'b0;
            in1      <= 1'b0;
            rom_addr <= '0;
        end else begin
            v1       <= pixel_valid;
            in1      <= pixel_valid && in_box;
            rom_addr <= (pixel_valid && in_box) ? addr_next : '0;
        end
    end

    assign hit_next = in1 && (rom_color != TRANSPARENT);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            out_valid    <= 1'b0;
            sprite_hit   <= 1'b0;
            sprite_color <= '0;
        end else begin
            out_valid    <= v1;
            sprite_hit   <= hit_next;
            sprite_color <= hit_next ? rom_color : 24'h0;
        end
    end

endmodule
